// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the multi-cycle divide controller.
package div_sequencer_pkg;

    localparam int DIV_W       = 32;
    localparam int DIV_CNT_W   = $clog2(DIV_W);
    localparam int DIV_LATENCY = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // 32-bit zero-detect gate shared with the rest of the execute stage.
    function automatic logic is_zero32(input logic [DIV_W-1:0] v);
        return ~|v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quot} left, trial-subtract
// the divisor and keep the difference when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor <= 2^(WIDTH-1) keeps shifted below 2^WIDTH, so the top
    // bit of the WIDTH+1 bit trial is a reliable borrow indicator.
    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next  = trial[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = shifted[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Signed divide controller: sign/magnitude conversion, bit counter and FSM
// around a single div_step. One operation in flight; a new ctrl_div in any
// state (re)starts the unit. Handshake: ctrl_div is a one-cycle request that
// is always accepted; result_rdy is a one-cycle strobe marking result and
// exception valid, and both hold their value until the next completion.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_rdy,
    output logic             busy,
    output div_state_e       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quot;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             b_zero;

    // Magnitude at WIDTH+1 bits so the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        logic [WIDTH:0] neg;
        ext = {v[WIDTH-1], v};
        neg = '0 - ext;
        return v[WIDTH-1] ? neg[WIDTH-1:0] : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem_q),
        .quot      (quot_q),
        .divisor   (dvsr_q),
        .rem_next  (step_rem),
        .quot_next (step_quot)
    );

    // Operand conditioning for a start.
    always_comb begin
        abs_a  = abs_val(operand_a);
        abs_b  = abs_val(operand_b);
        b_zero = is_zero32(operand_b);
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvsr_d   = dvsr_q;
        neg_d    = neg_q;
        result_d = result_q;
        exc_d    = exc_q;

        case (state_q)
            RUN: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = neg_q ? ('0 - quot_q) : quot_q;
                exc_d    = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start wins in every state; an operation in RUN/FIX is abandoned.
        if (ctrl_div) begin
            if (b_zero) begin
                state_d  = DONE;
                result_d = '0;
                exc_d    = 1'b1;
            end else begin
                state_d  = RUN;
                cnt_d    = '0;
                rem_d    = '0;
                quot_d   = abs_a;
                dvsr_d   = abs_b;
                neg_d    = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                result_d = result_q;
                exc_d    = exc_q;
            end
        end

        rdy_d  = (state_d == DONE);
        busy_d = (state_d == RUN) || (state_d == FIX);
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvsr_q   <= dvsr_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign result     = result_q;
    assign exception  = exc_q;
    assign result_rdy = rdy_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: a vector table of single divides plus
// hand-written abort, reset and back-to-back sequences.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        ctrl_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        exception;
    logic        result_rdy;
    logic        busy;
    div_state_e  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    div_sequencer #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ctrl_div   (ctrl_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .result     (result),
        .exception  (exception),
        .result_rdy (result_rdy),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          rdy_idx;   // sample index (cycles after E0) of the strobe
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one divide and watch 45 sample points (index n = after edge En).
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          output int pulses, output int first_idx,
                          output logic [31:0] res, output logic exc,
                          output logic busy0, output logic busy32,
                          output logic busy33, output logic busy_any);
        pulses    = 0;
        first_idx = -1;
        res       = 'x;
        exc       = 1'bx;
        busy0     = 1'b0;
        busy32    = 1'b0;
        busy33    = 1'b0;
        busy_any  = 1'b0;
        ctrl_div  = 1'b1;
        operand_a = a;
        operand_b = b;
        for (int n = 0; n < 45; n++) begin
            tick();
            if (n == 0) begin
                ctrl_div  = 1'b0;
                operand_a = $urandom();
                operand_b = $urandom();
            end
            if (busy) busy_any = 1'b1;
            if (n == 0)  busy0  = busy;
            if (n == 32) busy32 = busy;
            if (n == 33) busy33 = busy;
            if (result_rdy) begin
                pulses++;
                if (first_idx < 0) begin
                    first_idx = n;
                    res       = result;
                    exc       = exception;
                end
            end
        end
    endtask

    initial begin
        int          pulses;
        int          first_idx;
        logic [31:0] res;
        logic        exc;
        logic        b0, b32, b33, bany;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         1'b0, 33};
        vecs[1]  = '{-32'sd100,      32'd7,          32'hFFFF_FFF2,  1'b0, 33};
        vecs[2]  = '{32'd100,        -32'sd7,        32'hFFFF_FFF2,  1'b0, 33};
        vecs[3]  = '{-32'sd100,      -32'sd7,        32'd14,         1'b0, 33};
        vecs[4]  = '{32'd0,          32'd5,          32'd0,          1'b0, 33};
        vecs[5]  = '{32'd5,          32'd0,          32'd0,          1'b1, 0};
        vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 33};
        vecs[7]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 33};
        vecs[8]  = '{32'd7,          32'h8000_0000,  32'd0,          1'b0, 33};
        vecs[9]  = '{32'd1000,       32'd3,          32'd333,        1'b0, 33};
        vecs[10] = '{32'hFFFF_FFFF,  32'd2,          32'd0,          1'b0, 33};
        vecs[11] = '{32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, 33};
        vecs[12] = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};

        reset_n   = 1'b0;
        ctrl_div  = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) tick();

        check("rst_result",     result,     32'd0);
        check("rst_exception",  exception,  32'd0);
        check("rst_result_rdy", result_rdy, 32'd0);
        check("rst_busy",       busy,       32'd0);
        check("rst_state",      32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;
        tick();

        // Table of single divides.
        for (int i = 0; i < 13; i++) begin
            do_div(vecs[i].a, vecs[i].b, pulses, first_idx, res, exc, b0, b32, b33, bany);
            check($sformatf("v%0d_result", i),    res,       vecs[i].res);
            check($sformatf("v%0d_exception", i), exc,       vecs[i].exc);
            check($sformatf("v%0d_rdy_idx", i),   first_idx, vecs[i].rdy_idx);
            check($sformatf("v%0d_pulses", i),    pulses,    32'd1);
            if (vecs[i].exc) begin
                check($sformatf("v%0d_busy_never", i), bany, 32'd0);
            end else begin
                check($sformatf("v%0d_busy_first", i), b0,  32'd1);
                check($sformatf("v%0d_busy_last", i),  b32, 32'd1);
                check($sformatf("v%0d_busy_done", i),  b33, 32'd0);
            end
        end
        check("latency_const", 32'(DIV_LATENCY), vecs[0].rdy_idx);

        // Abort: 1000/3, restart with 50/5 sampled on E10.
        begin
            int p = 0;
            int fi = -1;
            logic [31:0] r = 'x;
            ctrl_div  = 1'b1;
            operand_a = 32'd1000;
            operand_b = 32'd3;
            for (int n = 0; n <= 80; n++) begin
                tick();
                if (n == 0 || n == 10) ctrl_div = 1'b0;
                if (n == 9) begin
                    ctrl_div  = 1'b1;
                    operand_a = 32'd50;
                    operand_b = 32'd5;
                end
                if (result_rdy) begin
                    p++;
                    if (fi < 0) begin
                        fi = n;
                        r  = result;
                    end
                end
            end
            check("abort_pulses", p,  32'd1);
            check("abort_idx",    fi, 32'd43);
            check("abort_result", r,  32'd10);
        end

        // Reset mid-operation at cycle 15, then a clean divide.
        begin
            logic rdy_seen = 1'b0;
            ctrl_div  = 1'b1;
            operand_a = 32'd1000;
            operand_b = 32'd3;
            for (int n = 0; n <= 15; n++) begin
                tick();
                if (n == 0) ctrl_div = 1'b0;
            end
            check("mid_busy_before", busy, 32'd1);
            reset_n = 1'b0;
            #1;
            check("mid_rst_busy",   busy,       32'd0);
            check("mid_rst_result", result,     32'd0);
            check("mid_rst_exc",    exception,  32'd0);
            check("mid_rst_rdy",    result_rdy, 32'd0);
            check("mid_rst_state",  32'(dbg_state), 32'(IDLE));
            for (int n = 0; n < 3; n++) begin
                tick();
                if (result_rdy) rdy_seen = 1'b1;
            end
            reset_n = 1'b1;
            for (int n = 0; n < 40; n++) begin
                tick();
                if (result_rdy) rdy_seen = 1'b1;
            end
            check("mid_rst_no_strobe", rdy_seen, 32'd0);
            do_div(32'd1000, 32'd3, pulses, first_idx, res, exc, b0, b32, b33, bany);
            check("post_rst_result", res,       32'd333);
            check("post_rst_idx",    first_idx, 32'd33);
            check("post_rst_pulses", pulses,    32'd1);
        end

        // Back-to-back: 100/7, then 50/5 issued in the DONE cycle.
        begin
            int p = 0;
            int fi = -1;
            logic [31:0] r = 'x;
            ctrl_div  = 1'b1;
            operand_a = 32'd100;
            operand_b = 32'd7;
            for (int n = 0; n <= 90; n++) begin
                tick();
                if (n == 0 || n == 34) ctrl_div = 1'b0;
                if (n == 33) begin
                    check("b2b_first_rdy",    result_rdy, 32'd1);
                    check("b2b_first_result", result,     32'd14);
                    ctrl_div  = 1'b1;
                    operand_a = 32'd50;
                    operand_b = 32'd5;
                end
                if (n >= 34 && result_rdy) begin
                    p++;
                    if (fi < 0) begin
                        fi = n;
                        r  = result;
                    end
                end
            end
            check("b2b_pulses", p,  32'd1);
            check("b2b_idx",    fi, 32'd67);
            check("b2b_result", r,  32'd10);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
